// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_op_sequencer                                             |
// | Description : Queues ALU requests, issues them one at a time to the        |
// |               combinational ALU, samples the result after a settle window  |
// |               and returns it on a valid/ready response port.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_ctrl,
  input  logic [1:0]       req_bshift,
  input  logic             req_select,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       alu_bshift,
  output logic             alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [7:0]       op_count,
  output logic             busy
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_pw = 2 * WIDTH + 6;
  localparam int c_cw = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_aw:0]   c_depth       = DEPTH[c_aw:0];
  localparam logic [c_cw-1:0] c_settle_init = c_cw'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_pw-1:0]  r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic [c_cw-1:0]  r_settle;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_ctrl;
  logic [1:0]       r_alu_bshift;
  logic             r_alu_select;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic [7:0]       r_op_count;

  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_accept;
  logic             w_not_empty;
  logic [c_pw-1:0]  w_head;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign req_ready   = reset && (r_count < c_depth);
  assign w_push      = req_valid && req_ready;
  assign w_not_empty = (r_count != '0);
  assign w_head      = r_mem[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (r_settle == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_accept = 1'b1;
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = DRIVE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {req_a, req_b, req_ctrl, req_bshift, req_select};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_settle     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctrl   <= '0;
      r_alu_bshift <= '0;
      r_alu_select <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_op_count   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        {r_alu_a, r_alu_b, r_alu_ctrl, r_alu_bshift, r_alu_select} <= w_head;
        r_settle <= c_settle_init;
      end else if (r_state == DRIVE && r_settle != '0) begin
        r_settle <= r_settle - 1'b1;
      end
      if (w_capture) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_result <= alu_result;
        r_rsp_flags  <= alu_flags;
      end else if (w_accept) begin
        r_rsp_valid <= 1'b0;
        r_op_count  <= r_op_count + 8'd1;
      end
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_ctrl   = r_alu_ctrl;
  assign alu_bshift = r_alu_bshift;
  assign alu_select = r_alu_select;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign op_count   = r_op_count;
  assign busy       = (r_state != IDLE) || w_not_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_op_sequencer                                          |
// | Description : Self-checking bench for alu_op_sequencer (SETTLE=1 and 3).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  int         checks = 0;
  int         errors = 0;

  logic       req_valid, req_ready, req_select, alu_select, rsp_valid, rsp_ready, busy;
  logic [4:0] req_a, req_b, alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] req_ctrl, alu_ctrl;
  logic [1:0] req_bshift, alu_bshift;
  logic [3:0] alu_flags, rsp_flags;
  logic [7:0] op_count;

  logic       req_valid3, req_ready3, req_select3, alu_select3, rsp_valid3, rsp_ready3, busy3;
  logic [4:0] req_a3, req_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
  logic [2:0] req_ctrl3, alu_ctrl3;
  logic [1:0] req_bshift3, alu_bshift3;
  logic [3:0] alu_flags3, rsp_flags3;
  logic [7:0] op_count3;

  logic [1:0] stub_mode;
  logic [4:0] force_res;
  logic [3:0] force_flg;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_ctrl(req_ctrl), .req_bshift(req_bshift), .req_select(req_select),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_bshift(alu_bshift),
    .alu_select(alu_select), .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .op_count(op_count), .busy(busy)
  );

  alu_op_sequencer #(.SETTLE(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_a(req_a3), .req_b(req_b3),
    .req_ctrl(req_ctrl3), .req_bshift(req_bshift3), .req_select(req_select3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_ctrl3), .alu_bshift(alu_bshift3),
    .alu_select(alu_select3), .alu_result(alu_result3), .alu_flags(alu_flags3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_flags(rsp_flags3), .op_count(op_count3), .busy(busy3)
  );

  // Stand-in ALU: an arbitrary function of the issued operation.
  function automatic logic [4:0] f_res(input logic [4:0] a, input logic [4:0] b,
                                       input logic [2:0] c, input logic [1:0] s,
                                       input logic sel);
    logic [4:0] sh;
    sh = b << s;
    return (a + sh) ^ {c, sel, 1'b0};
  endfunction

  function automatic logic [3:0] f_flg(input logic [4:0] a, input logic [4:0] b,
                                       input logic [2:0] c, input logic [1:0] s,
                                       input logic sel);
    return {c, sel} ^ {b[1:0], s} ^ {a[3:0]};
  endfunction

  always_comb begin
    alu_result = f_res(alu_a, alu_b, alu_ctrl, alu_bshift, alu_select);
    alu_flags  = f_flg(alu_a, alu_b, alu_ctrl, alu_bshift, alu_select);
    if (stub_mode == 2'd1) begin
      alu_result = force_res;
      alu_flags  = force_flg;
    end else if (stub_mode == 2'd2) begin
      alu_result = alu_a + 5'd1;
      alu_flags  = 4'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [4:0] a, input logic [4:0] b, input logic [2:0] c,
                         input logic [1:0] s, input logic sel);
    req_valid = 1'b1; req_a = a; req_b = b; req_ctrl = c; req_bshift = s; req_select = sel;
  endtask

  task automatic drain_one(input string tag, input logic [4:0] er, input logic [3:0] ef);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_result"}, rsp_result, er);
    chk({tag, "_flags"}, rsp_flags, ef);
    tick();
  endtask

  logic [4:0] fa [6];
  logic [4:0] fb [6];
  logic [2:0] fc [6];
  logic [1:0] fs [6];
  logic       fsel [6];
  int         tstamp [3];
  logic [8:0] exp_q [$];
  logic [8:0] e;
  int         k;
  int         done;
  int         n;

  initial begin
    reset = 1'b1;
    stub_mode = 2'd0; force_res = '0; force_flg = '0;
    req_valid = 0; req_a = 0; req_b = 0; req_ctrl = 0; req_bshift = 0; req_select = 0;
    rsp_ready = 0;
    req_valid3 = 0; req_a3 = 0; req_b3 = 0; req_ctrl3 = 0; req_bshift3 = 0; req_select3 = 0;
    rsp_ready3 = 0; alu_result3 = 5'd7; alu_flags3 = 4'd3;
    #2 reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rel_req_ready", req_ready, 1);
    tick();

    // Single operation with fixed stub output.
    stub_mode = 2'd1; force_res = 5'd31; force_flg = 4'b1000;
    set_req(5'd4, 5'd5, 3'b001, 2'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("single_alu_pre", alu_a, 0);
    chk("single_busy", busy, 1);
    tick();
    chk("single_alu_a", alu_a, 4);
    chk("single_alu_b", alu_b, 5);
    chk("single_alu_ctrl", alu_ctrl, 1);
    chk("single_rsp_early", rsp_valid, 0);
    tick();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_result", rsp_result, 31);
    chk("single_rsp_flags", rsp_flags, 4'b1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_rsp_done", rsp_valid, 0);
    chk("single_op_count", op_count, 1);
    chk("single_busy_end", busy, 0);

    // Fill the FIFO while responses are blocked.
    stub_mode = 2'd0;
    for (int i = 0; i < 6; i++) begin
      fa[i] = 5'(10 + i); fb[i] = 5'(3 * i + 1); fc[i] = 3'(i); fs[i] = 2'(i); fsel[i] = i[0];
    end
    for (int i = 0; i < 5; i++) begin
      set_req(fa[i], fb[i], fc[i], fs[i], fsel[i]);
      chk("fill_ready", req_ready, 1);
      tick();
    end
    chk("full_ready", req_ready, 0);
    set_req(fa[5], fb[5], fc[5], fs[5], fsel[5]);
    for (int i = 0; i < 3; i++) begin
      chk("full_hold", req_ready, 0);
      chk("full_rsp", rsp_valid, 1);
      tick();
    end
    chk("fill_r0", rsp_result, f_res(fa[0], fb[0], fc[0], fs[0], fsel[0]));
    chk("fill_f0", rsp_flags, f_flg(fa[0], fb[0], fc[0], fs[0], fsel[0]));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("full_after_pop", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("full_again", req_ready, 0);
    for (int i = 1; i < 6; i++)
      drain_one("fill_drain", f_res(fa[i], fb[i], fc[i], fs[i], fsel[i]),
                f_flg(fa[i], fb[i], fc[i], fs[i], fsel[i]));
    rsp_ready = 1'b0;
    chk("fill_busy_end", busy, 0);
    chk("fill_op_count", op_count, 7);

    // Back-to-back responses with rsp_ready held high.
    stub_mode = 2'd2;
    for (int i = 1; i <= 3; i++) begin
      set_req(5'(i), 5'd0, 3'd0, 2'd0, 1'b0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (rsp_valid) begin
        chk("b2b_result", rsp_result, 5'(k + 2));
        if (k < 3) tstamp[k] = cyc;
        k++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    chk("b2b_count", k, 3);
    chk("b2b_gap1", tstamp[1] - tstamp[0], 2);
    chk("b2b_gap2", tstamp[2] - tstamp[1], 2);
    chk("b2b_busy", busy, 0);
    chk("b2b_op_count", op_count, 10);

    // Backpressure: captured value must not follow the changing ALU output.
    stub_mode = 2'd1; force_res = 5'd17; force_flg = 4'd5;
    set_req(5'd9, 5'd1, 3'd2, 2'd1, 1'b1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_valid", rsp_valid, 1);
    chk("bp_result", rsp_result, 17);
    for (int i = 0; i < 5; i++) begin
      force_res = 5'($urandom); force_flg = 4'($urandom);
      tick();
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_result", rsp_result, 17);
      chk("bp_hold_flags", rsp_flags, 5);
      chk("bp_hold_alu_a", alu_a, 9);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_op_count", op_count, 11);

    // SETTLE=3 instance: the sample is taken three cycles after issue.
    req_valid3 = 1'b1; req_a3 = 5'd6; req_b3 = 5'd2; alu_result3 = 5'd7; alu_flags3 = 4'd3;
    tick();
    req_valid3 = 1'b0;
    chk("s3_alu_pre", alu_a3, 0);
    tick();
    chk("s3_alu_a", alu_a3, 6);
    chk("s3_rsp_e1", rsp_valid3, 0);
    tick();
    alu_result3 = 5'd9;
    chk("s3_rsp_e2", rsp_valid3, 0);
    tick();
    chk("s3_rsp_e3", rsp_valid3, 0);
    tick();
    chk("s3_rsp_valid", rsp_valid3, 1);
    chk("s3_rsp_result", rsp_result3, 9);
    chk("s3_rsp_flags", rsp_flags3, 3);
    rsp_ready3 = 1'b1;
    tick();
    rsp_ready3 = 1'b0;
    chk("s3_op_count", op_count3, 1);

    // Asynchronous reset while an op is in DRIVE with two more queued.
    for (int i = 1; i <= 3; i++) begin
      req_valid3 = 1'b1; req_a3 = 5'(i);
      tick();
    end
    req_valid3 = 1'b0;
    chk("ar_busy_before", busy3, 1);
    chk("ar_rsp_before", rsp_valid3, 0);
    #3 reset = 1'b0;
    #1;
    chk("ar_alu_a3", alu_a3, 0);
    chk("ar_busy3", busy3, 0);
    chk("ar_op_count3", op_count3, 0);
    chk("ar_req_ready3", req_ready3, 0);
    chk("ar_alu_a", alu_a, 0);
    chk("ar_op_count", op_count, 0);
    chk("ar_rsp_result", rsp_result, 0);
    tick();
    chk("ar_hold_alu_a3", alu_a3, 0);
    reset = 1'b1;
    tick();
    chk("ar_rel_ready3", req_ready3, 1);
    for (int i = 0; i < 8; i++) begin
      chk("ar_no_rsp", rsp_valid3, 0);
      chk("ar_idle", busy3, 0);
      tick();
    end

    // Randomised traffic against a queue model, long enough to wrap op_count.
    stub_mode = 2'd0;
    done = 0;
    for (int cyc = 0; cyc < 6000 && done < 260; cyc++) begin
      req_valid  = ($urandom_range(3) != 0);
      req_a      = 5'($urandom);
      req_b      = 5'($urandom);
      req_ctrl   = 3'($urandom);
      req_bshift = 2'($urandom);
      req_select = 1'($urandom);
      rsp_ready  = ($urandom_range(3) != 0);
      chk("rnd_busy", busy, (exp_q.size() != 0));
      chk("rnd_op_count", op_count, done[7:0]);
      if (done == 256) chk("rnd_wrap", op_count, 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_result", rsp_result, e[8:4]);
          chk("rnd_flags", rsp_flags, e[3:0]);
        end
        done++;
      end
      if (req_valid && req_ready)
        exp_q.push_back({f_res(req_a, req_b, req_ctrl, req_bshift, req_select),
                         f_flg(req_a, req_b, req_ctrl, req_bshift, req_select)});
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rnd_completed", (done >= 260), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
